// File: rtl/mem_block_copier.sv
// mem_block_copier: bulk word-copy engine on the single-port data memory.
// Copies `length` words from src_addr to dst_addr, one read cycle then one
// write cycle per word, strictly forward (overlapping ranges are defined).
// Optional feature: define MEM_COPY_CHECKSUM_EN to add the `checksum` port
// and a running DATA_W-bit sum of every word read during a copy.
module mem_block_copier #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q,       state_d;
  logic [ADDR_W-1:0]   src_ptr_q,     src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q,     dst_ptr_d;
  logic [LEN_W-1:0]    remaining_q,   remaining_d;
  logic [DATA_W-1:0]   data_q,        data_d;
  logic                busy_q,        busy_d;
  logic                done_q,        done_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic                mem_we_q,      mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q,   mem_wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q,        csum_d;
`endif

  // Next-state, datapath and next-output computation; memory-side outputs are
  // decoded from the next state so they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MEM_COPY_CHECKSUM_EN
          csum_d = '0;
`endif
          if (length != '0) begin
            src_ptr_d   = src_addr;
            dst_ptr_d   = dst_addr;
            remaining_d = length;
            state_d     = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        data_d  = mem_read_data;
`ifdef MEM_COPY_CHECKSUM_EN
        csum_d  = csum_q + mem_read_data;
`endif
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_ptr_d   = src_ptr_q + ADDR_W'(1);
        dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
        remaining_d = remaining_q - LEN_W'(1);
        state_d     = (remaining_q == LEN_W'(1)) ? S_DONE : S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    mem_address_d = '0;
    mem_we_d      = 1'b0;
    mem_wdata_d   = '0;
    unique case (state_d)
      S_READ: begin
        mem_address_d = src_ptr_d;
      end
      S_WRITE: begin
        mem_address_d = dst_ptr_d;
        mem_we_d      = 1'b1;
        mem_wdata_d   = data_d;
      end
      default: begin
        mem_address_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything so an aborted copy
  // drops write_enable before the next falling edge and never pulses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      src_ptr_q     <= '0;
      dst_ptr_q     <= '0;
      remaining_q   <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_address_q <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      src_ptr_q     <= src_ptr_d;
      dst_ptr_q     <= dst_ptr_d;
      remaining_q   <= remaining_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_address_q <= mem_address_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign mem_address      = mem_address_q;
  assign mem_write_enable = mem_we_q;
  assign mem_write_data   = mem_wdata_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum         = csum_q;
`endif

endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier: drives mem_block_copier against a 1024x16 memory with
// falling-edge writes; a reference model predicts every output per cycle.
// Build with MEM_COPY_CHECKSUM_EN defined to also check the checksum port.
module tb_mem_block_copier;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LW = 11;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic          mem_write_enable;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  mem_block_copier #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];

  function automatic logic [DW-1:0] init_val(input int a);
    if (a >= 500 && a <= 509) return DW'(a - 499);
    if (a >= 1020)            return 16'hA001 + DW'(a - 1020);
    if (a <= 3)               return 16'hA005 + DW'(a);
    return DW'(a * 37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: combinational read, write committed on the falling edge
  initial begin : memory
    for (int a = 0; a < 1024; a++) mem[a] = init_val(a);
    forever begin
      @(negedge clk);
      if (mem_write_enable === 1'b1) mem[mem_address] = mem_write_data;
    end
  end

  // Reference model: a copy is a list of words computed up front by a forward
  // word-by-word copy on the model memory; edge k after accept selects the word.
  initial begin : monitor
    logic [DW-1:0] scr [1024];
    logic [DW-1:0] m_exp [$];
    logic [DW-1:0] m_csum;
    bit            m_active;
    int            m_k, m_n, m_src, m_dst, wi;
    logic          e_busy, e_done, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    m_active = 1'b0;
    m_csum   = '0;
    m_k = 0; m_n = 0; m_src = 0; m_dst = 0;
    for (int a = 0; a < 1024; a++) ref_mem[a] = init_val(a);
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 1'b0;
        m_csum   = '0;
      end else if (m_active) begin
        m_k++;
        if (m_k > 2 * m_n) begin
          m_active = 1'b0;
        end else if (m_k % 2 == 1) begin
          wi = (m_k - 1) / 2;
          m_csum = m_csum + m_exp[wi];
          ref_mem[(m_dst + wi) % 1024] = m_exp[wi];
        end
      end else if (start) begin
        m_active = 1'b1;
        m_k   = 0;
        m_n   = int'(length);
        m_src = int'(src_addr);
        m_dst = int'(dst_addr);
        m_csum = '0;
        scr = ref_mem;
        m_exp.delete();
        for (int i = 0; i < m_n; i++) begin
          m_exp.push_back(scr[(m_src + i) % 1024]);
          scr[(m_dst + i) % 1024] = scr[(m_src + i) % 1024];
        end
      end
      #1;
      e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (m_active) begin
        e_busy = 1'b1;
        if (m_k == 2 * m_n) begin
          e_done = 1'b1;
        end else if (m_k % 2 == 0) begin
          e_addr = AW'((m_src + m_k / 2) % 1024);
        end else begin
          e_addr = AW'((m_dst + (m_k - 1) / 2) % 1024);
          e_we   = 1'b1;
          e_wd   = m_exp[(m_k - 1) / 2];
        end
      end
      chk("busy",  32'(busy),             32'(e_busy));
      chk("done",  32'(done),             32'(e_done));
      chk("addr",  32'(mem_address),      32'(e_addr));
      chk("we",    32'(mem_write_enable), 32'(e_we));
      chk("wdata", 32'(mem_write_data),   32'(e_wd));
`ifdef MEM_COPY_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(m_csum));
`endif
    end
  end

  // One copy: cycle c is the c-th falling edge after the accept edge.
  task automatic copy(input int s, input int d, input int l, input int poke_at,
                      input int rst_at, output int done_at, output int busy_cnt,
                      output int we_cnt);
    bit finished;
    finished = 1'b0;
    done_at = -1; busy_cnt = 0; we_cnt = 0;
    @(negedge clk);
    start = 1'b1; src_addr = AW'(s); dst_addr = AW'(d); length = LW'(l);
    for (int c = 1; c <= 2 * l + 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        src_addr = AW'($urandom); dst_addr = AW'($urandom); length = LW'($urandom);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (mem_write_enable === 1'b1) we_cnt++;
      if (rst) rst = 1'b0;
      if (c == poke_at) begin
        start = 1'b1;
        src_addr = AW'($urandom); dst_addr = AW'($urandom);
        length = LW'($urandom_range(1, 40));
      end else if (c == poke_at + 1) begin
        start = 1'b0;
      end
      if (c == rst_at) rst = 1'b1;
      if (busy === 1'b0) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    chk("copy_returns_idle", 32'(finished), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int da, bc, wc, s, d, l, ra, pk, mism;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  32'(busy),             32'd0);
    chk("reset_done",  32'(done),             32'd0);
    chk("reset_we",    32'(mem_write_enable), 32'd0);
    chk("reset_addr",  32'(mem_address),      32'd0);
    chk("reset_wdata", 32'(mem_write_data),   32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("reset_checksum", 32'(checksum), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 10-word copy 500 -> 600
    copy(500, 600, 10, 0, 0, da, bc, wc);
    chk("t1_done_cycle", da, 21);
    chk("t1_busy_cycles", bc, 21);
    chk("t1_writes", wc, 10);
    for (int i = 0; i < 10; i++) chk("t1_word", 32'(mem[600 + i]), 32'(i + 1));
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t1_checksum", 32'(checksum), 32'd55);
`endif

    // zero length
    copy(123, 456, 0, 0, 0, da, bc, wc);
    chk("len0_done_cycle", da, 1);
    chk("len0_busy_cycles", bc, 1);
    chk("len0_writes", wc, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("len0_checksum", 32'(checksum), 32'd0);
`endif

    // address wrap 1020 -> 100
    copy(1020, 100, 8, 0, 0, da, bc, wc);
    for (int i = 0; i < 8; i++) chk("wrap_word", 32'(mem[100 + i]), 32'(16'hA001 + i));

    // overlapping forward copy
    copy(500, 501, 3, 0, 0, da, bc, wc);
    for (int i = 0; i < 3; i++) chk("overlap_word", 32'(mem[501 + i]), 32'd1);

    // start pulsed while busy
    copy(200, 300, 6, 4, 0, da, bc, wc);
    chk("midstart_done_cycle", da, 13);
    for (int i = 0; i < 6; i++) chk("midstart_word", 32'(mem[300 + i]), 32'(init_val(200 + i)));

    // reset during the third write cycle of a 10-word copy
    copy(700, 800, 10, 0, 6, da, bc, wc);
    chk("rst_no_done", da, -1);
    chk("rst_after_we",   32'(mem_write_enable), 32'd0);
    chk("rst_after_addr", 32'(mem_address),      32'd0);
    chk("rst_after_busy", 32'(busy),             32'd0);
    for (int i = 0; i < 10; i++)
      chk("rst_word", 32'(mem[800 + i]), 32'(init_val(i < 3 ? 700 + i : 800 + i)));
    @(negedge clk);

    // randomized copies
    for (int t = 0; t < 30; t++) begin
      s = $urandom_range(0, 1023);
      d = $urandom_range(0, 1023);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      ra = (t % 5 == 4 && l > 2) ? $urandom_range(1, 2 * l - 1) : 0;
      pk = (ra == 0 && l > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * l - 2) : 0;
      copy(s, d, l, pk, ra, da, bc, wc);
      if (ra == 0) begin
        chk("rand_done_cycle", da, 2 * l + 1);
        chk("rand_busy_cycles", bc, 2 * l + 1);
        chk("rand_writes", wc, l);
      end else begin
        chk("rand_rst_no_done", da, -1);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    mism = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== ref_mem[a]) mism++;
    chk("memory_image", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
